// File: rtl/fxp_mac_stream.sv
// Pipelined signed fixed-point multiply-accumulate over valid/ready packets.
// One rounded, saturated result is produced for each in_last-delimited packet.
module fxp_mac_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int FIXED_PNT  = 8,
    parameter int GUARD      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [DATA_WIDTH-1:0] num1,
    input  logic [DATA_WIDTH-1:0] num2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW    = 2 * DATA_WIDTH;
    localparam int ACC_W = PW + GUARD;

    logic                    w_adv;
    logic                    w_accept;
    logic                    w_step;
    logic                    w_load;
    logic signed [PW-1:0]    w_prod;
    logic signed [ACC_W-1:0] w_p1_ext;
    logic signed [ACC_W-1:0] w_acc_base;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [ACC_W:0]   w_round;
    logic [ACC_W:DATA_WIDTH-1] w_upper;
    logic                    w_ovf;
    logic                    w_unf;
    logic [DATA_WIDTH-1:0]   w_sat;

    logic signed [PW-1:0]    r_p1;
    logic                    r_v1;
    logic                    r_l1;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_first;
    logic                    r_out_valid;
    logic [DATA_WIDTH-1:0]   r_result;
    logic                    r_ovf;
    logic                    r_unf;

    // The whole pipeline moves in lockstep; a held result freezes every stage.
    assign w_adv    = ~r_out_valid | out_ready;
    assign w_accept = in_valid & w_adv;
    assign w_step   = w_adv & r_v1;
    assign w_load   = w_step & r_l1;

    assign w_prod     = $signed(num1) * $signed(num2);
    assign w_p1_ext   = ACC_W'(r_p1);
    assign w_acc_base = r_first ? '0 : r_acc;
    assign w_acc_next = w_acc_base + w_p1_ext;

    generate
        if (FIXED_PNT > 0) begin : g_round
            localparam logic [ACC_W:0] HALF =
                (ACC_W+1)'(1) << (FIXED_PNT - 1);
            logic [ACC_W:0] w_wide;
            assign w_wide  = {w_acc_next[ACC_W-1], w_acc_next} + HALF;
            assign w_round = $signed(w_wide) >>> FIXED_PNT;
        end else begin : g_noround
            assign w_round = {w_acc_next[ACC_W-1], w_acc_next};
        end
    endgenerate

    // In range iff every bit from the result sign upward matches.
    assign w_upper = w_round[ACC_W:DATA_WIDTH-1];
    assign w_ovf   = ~w_round[ACC_W] & (|w_upper);
    assign w_unf   =  w_round[ACC_W] & ~(&w_upper);

    always_comb begin
        w_sat = w_round[DATA_WIDTH-1:0];
        if (w_ovf) begin
            w_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (w_unf) begin
            w_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p1 <= '0;
            r_v1 <= 1'b0;
            r_l1 <= 1'b0;
        end else if (w_adv) begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_p1 <= w_prod;
                r_l1 <= in_last;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_first <= 1'b1;
        end else if (w_step) begin
            r_acc   <= w_acc_next;
            r_first <= r_l1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_result    <= w_sat;
            r_ovf       <= w_ovf;
            r_unf       <= w_unf;
        end else if (r_out_valid & out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule

// File: tb/tb_fxp_mac_stream.sv
// Directed bench for fxp_mac_stream (Q7.8 operands, 8 guard bits).
// Results consumed downstream are queued and compared to hand-computed values.
module tb_fxp_mac_stream;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [15:0] num1;
    logic [15:0] num2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    logic [17:0] obs_q[$];

    fxp_mac_stream #(
        .DATA_WIDTH(16),
        .FIXED_PNT (8),
        .GUARD     (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .num1     (num1),
        .num2     (num2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .overflow (overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every result that is consumed at the upcoming edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready)
            obs_q.push_back({overflow, underflow, result});
    end

    task automatic push(input logic [15:0] a, input logic [15:0] b,
                        input logic last);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        num1     = a;
        num2     = b;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL push_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_res(input string name, input logic [15:0] er,
                              input logic eo, input logic eu);
        int n;
        logic [17:0] got;
        n = 0;
        while (obs_q.size() == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL %s: no result observed, required %h", name, er);
        end else begin
            got = obs_q.pop_front();
            if (got !== {eo, eu, er}) begin
                errors++;
                $display("FAIL %s: got result=%h ovf=%0b unf=%0b, required result=%h ovf=%0b unf=%0b",
                         name, got[15:0], got[17], got[16], er, eo, eu);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({out_valid, result, overflow, underflow, in_ready} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: ov=%0b res=%h of=%0b uf=%0b rdy=%0b required 0 0000 0 0 1",
                     out_valid, result, overflow, underflow, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_single();
        push(16'h0180, 16'h0200, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_edge1: out_valid=%0b required 0", out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_edge2: out_valid=%0b required 1", out_valid);
        end
        expect_res("single", 16'h0300, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        push(16'h0100, 16'h0100, 1'b0);
        push(16'h0200, 16'hFF80, 1'b0);
        push(16'h0040, 16'h0400, 1'b1);
        push(16'h0200, 16'h0200, 1'b1);
        expect_res("dot_product", 16'h0100, 1'b0, 1'b0);
        expect_res("acc_cleared", 16'h0400, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        push(16'h7F00, 16'h0200, 1'b1);
        expect_res("sat_pos", 16'h7FFF, 1'b1, 1'b0);
        push(16'h8000, 16'h0200, 1'b1);
        expect_res("sat_neg", 16'h8000, 1'b0, 1'b1);
        for (int i = 0; i < 256; i++)
            push(16'h7FFF, 16'h7FFF, (i == 255));
        expect_res("sat_256_terms", 16'h7FFF, 1'b1, 1'b0);
    endtask

    task automatic test_rounding();
        push(16'h0001, 16'h0080, 1'b1);
        expect_res("round_half_pos", 16'h0001, 1'b0, 1'b0);
        push(16'hFFFF, 16'h0080, 1'b1);
        expect_res("round_half_neg", 16'h0000, 1'b0, 1'b0);
        push(16'h0001, 16'h007F, 1'b1);
        expect_res("round_below_half", 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        push(16'h0100, 16'h0300, 1'b1);
        push(16'h0200, 16'h0100, 1'b0);
        in_valid = 1'b1;
        num1     = 16'h0100;
        num2     = 16'h0080;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({in_ready, out_valid, result, overflow, underflow} !==
                {1'b0, 1'b1, 16'h0300, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stall_%0d: rdy=%0b ov=%0b res=%h of=%0b uf=%0b required 0 1 0300 0 0",
                         i, in_ready, out_valid, result, overflow, underflow);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        expect_res("stalled_result", 16'h0300, 1'b0, 1'b0);
        expect_res("after_release", 16'h0280, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_packet();
        push(16'h0100, 16'h0100, 1'b0);
        push(16'h0100, 16'h0100, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, result, overflow, underflow, in_ready} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset: ov=%0b res=%h of=%0b uf=%0b rdy=%0b required 0 0000 0 0 1",
                     out_valid, result, overflow, underflow, in_ready);
        end
        #1;
        rst = 1'b0;
        obs_q.delete();
        push(16'h0100, 16'h0100, 1'b1);
        expect_res("after_mid_reset", 16'h0100, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL extra_results: %0d queued, required 0", obs_q.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        num1      = '0;
        num2      = '0;
        out_ready = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_saturation();
        test_rounding();
        test_backpressure();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
